// File: rtl/sixty_four_bit_mul.sv
// sixty_four_bit_mul: unsigned WIDTH x WIDTH -> 2*WIDTH iterative shift-and-add multiplier.
// One multiplier bit per clock with a start/busy/done handshake. Rev 1.0.
`default_nettype none

module sixty_four_bit_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0]   count;
  logic               load;
  logic               step;
  logic               last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST_CNT) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // mcand is kept pre-shifted by count, so each step adds it directly.
  assign acc_sum = acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        acc    <= '0;
        count  <= '0;
      end else if (step) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
      end
      if (last) begin
        product <= acc_sum;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sixty_four_bit_mul.sv
// tb_sixty_four_bit_mul: table, hand-written and random checks of the iterative multiplier
// against a plain-arithmetic reference product.
`default_nettype none

module tb_sixty_four_bit_mul;

  localparam int W   = 32;
  localparam int LAT = 32;
  localparam int MAX_WAIT = 40;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;

  sixty_four_bit_mul #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done is seen; product must hold meanwhile.
  task automatic wait_done(input logic [2*W-1:0] old_p, output int lat, output bit held);
    lat  = 0;
    held = 1'b1;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      tick();
      lat++;
      if (done !== 1'b1 && product !== old_p) held = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int lat;
    bit held;
    int d0;
    logic [2*W-1:0] old_p;
    old_p = product;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    check({name, " busy"}, 64'(busy), 64'd1);
    wait_done(old_p, lat, held);
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " product"}, product, exp);
    check({name, " held"}, 64'(held), 64'd1);
    tick();
    check({name, " done one cycle"}, 64'(done), 64'd0);
    check({name, " done count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int lat;
    bit held;
    int d0;
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] p1;

    vecs[0] = '{32'h0001AAAA, 32'h0000E439, 64'd6381529050};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[2] = '{32'h00000000, 32'h12345678, 64'h0};
    vecs[3] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF};
    vecs[5] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[6] = '{32'h00000002, 32'h80000000, 64'h00000001_00000000};

    // Reset with start held high: nothing may start.
    rst_n = 1'b0; start = 1'b1; A = 32'h1234; B = 32'h5678;
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post-reset busy", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Back-to-back: start held through the done cycle.
    a1 = 32'hE439CE83; b1 = 32'hC0E35A32;
    a2 = 32'h92974D62; b2 = 32'h892A0A85;
    d0 = done_cnt;
    A = a1; B = b1; start = 1'b1;
    tick();
    A = a2; B = b2;
    wait_done(product, lat, held);
    check("b2b first latency", 64'(lat), 64'(LAT));
    check("b2b first product", product, ref_mul(a1, b1));
    p1 = product;
    tick();
    start = 1'b0;
    check("b2b second accepted", 64'(busy), 64'd1);
    check("b2b old product kept", product, p1);
    wait_done(p1, lat, held);
    check("b2b second latency", 64'(lat), 64'(LAT));
    check("b2b second product", product, ref_mul(a2, b2));
    check("b2b second held", 64'(held), 64'd1);
    tick();
    check("b2b done count", 64'(done_cnt - d0), 64'd2);

    // Operand changes and start held while busy.
    d0 = done_cnt;
    A = 32'hDEADBEEF; B = 32'h00C0FFEE; start = 1'b1;
    tick();
    lat = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      A = $urandom; B = $urandom;
      if (lat >= LAT - 1) start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    check("busy-start latency", 64'(lat), 64'(LAT));
    check("busy-start product", product, ref_mul(32'hDEADBEEF, 32'h00C0FFEE));
    for (int i = 0; i < 5; i++) tick();
    check("busy-start no extra op", 64'(busy), 64'd0);
    check("busy-start done count", 64'(done_cnt - d0), 64'd1);

    // Reset at cycle 10 of an operation.
    A = 32'h0BADF00D; B = 32'h13579BDF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort product", product, 64'd0);
    check("abort done", 64'(done), 64'd0);
    for (int i = 0; i < MAX_WAIT; i++) tick();
    check("abort no done", 64'(done_cnt - d0), 64'd0);
    run_op("after abort", 32'h0BADF00D, 32'h13579BDF, ref_mul(32'h0BADF00D, 32'h13579BDF));

    // Random operands against the reference product.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = ra & 32'h0001FFFF;
      run_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
